// File: rtl/hash_mem_pkg.sv
// Shared dump-FSM state type, dump length limit and address range helper.
// Pure definitions; no latency or backpressure.
package hash_mem_pkg;

  localparam int DUMP_MAX = 16;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_RD   = 2'd1,
    DS_OUT  = 2'd2,
    DS_DONE = 2'd3
  } dump_state_t;

  // True when any address bit at or above aw is set; safe for aw == 16.
  function automatic logic addr_oob(input logic [15:0] a, input int unsigned aw);
    return (32'(a) >> aw) != 32'd0;
  endfunction

endpackage

// File: rtl/hash_mem_array.sv
// Word array, one write port and two registered read-first read ports.
// Read data one cycle after address; port B holds its word when i_re_b is low.
module hash_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [31:0]   o_rdata_a,
  input  logic          i_re_b,
  input  logic [AW-1:0] i_raddr_b,
  output logic [31:0]   o_rdata_b
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata_a;
  logic [31:0] r_rdata_b;

  // Storage is never reset; only the output registers are.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata_a <= 32'd0;
      r_rdata_b <= 32'd0;
    end else begin
      r_rdata_a <= r_mem[i_raddr_a];
      if (i_re_b) r_rdata_b <= r_mem[i_raddr_b];
    end
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/hash_mem_responder.sv
// Hash-initiator memory with host preload (hash side wins writes) and a dump streamer.
// Hash read latency 1 cycle; loads stall while mem_we=1; dump words held until dump_ready.
module hash_mem_responder
  import hash_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        load_valid,
  input  logic [15:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic        dump_start,
  input  logic [15:0] dump_addr,
  input  logic [4:0]  dump_len,
  output logic        dump_valid,
  output logic [31:0] dump_data,
  input  logic        dump_ready,
  output logic        dump_done,
  output logic        addr_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  dump_state_t   r_state;
  logic [AW-1:0] r_ptr;
  logic [4:0]    r_remaining;
  logic          r_addr_err;
  logic [15:0]   r_rd_count;
  logic [15:0]   r_wr_count;

  logic          w_load_acc;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;
  logic [4:0]    w_len;
  logic          w_capture;
  logic          w_dump_err;

  assign load_ready = !mem_we && !reset;
  assign w_load_acc = load_valid && load_ready;
  assign w_we       = mem_we ? !reset : w_load_acc;
  assign w_waddr    = mem_we ? mem_addr[AW-1:0] : load_addr[AW-1:0];
  assign w_wdata    = mem_we ? mem_write_data : load_data;

  assign w_len      = (dump_len > 5'(DUMP_MAX)) ? 5'(DUMP_MAX) : dump_len;
  assign w_capture  = (r_state == DS_IDLE) && dump_start;
  // Only the first dump address can carry high bits; later ones wrap inside AW.
  assign w_dump_err = w_capture && (w_len != 5'd0) && addr_oob(dump_addr, AW);

  hash_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (mem_addr[AW-1:0]),
    .o_rdata_a (mem_read_data),
    .i_re_b    (r_state == DS_RD),
    .i_raddr_b (r_ptr),
    .o_rdata_b (dump_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= DS_IDLE;
      r_ptr       <= '0;
      r_remaining <= 5'd0;
    end else begin
      case (r_state)
        DS_IDLE: if (dump_start) begin
          r_ptr       <= dump_addr[AW-1:0];
          r_remaining <= w_len;
          r_state     <= (w_len == 5'd0) ? DS_DONE : DS_RD;
        end
        DS_RD: r_state <= DS_OUT;
        DS_OUT: if (dump_ready) begin
          r_ptr       <= r_ptr + 1'b1;
          r_remaining <= r_remaining - 5'd1;
          r_state     <= (r_remaining == 5'd1) ? DS_DONE : DS_RD;
        end
        default: r_state <= DS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_err <= 1'b0;
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else begin
      if (addr_oob(mem_addr, AW) || (w_load_acc && addr_oob(load_addr, AW)) || w_dump_err)
        r_addr_err <= 1'b1;
      if (mem_we) begin
        if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
      end else begin
        if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      end
    end
  end

  assign dump_valid = (r_state == DS_OUT);
  assign dump_done  = (r_state == DS_DONE);
  assign addr_err   = r_addr_err;
  assign rd_count   = r_rd_count;
  assign wr_count   = r_wr_count;

endmodule
